// File: rtl/flash_pkg.sv
// flash_pkg: state codes and bus timing constants shared by the flash patch mover
package flash_pkg;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_REQ   = 3'd1;
    localparam logic [2:0] S_ERASE    = 3'd2;
    localparam logic [2:0] S_WR_FETCH = 3'd3;
    localparam logic [2:0] S_WR_REQ   = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;
    localparam logic [2:0] S_RETRY    = 3'd6;
    localparam logic [2:0] S_FINISH   = 3'd7;
    localparam int GAP_LEN      = 2;
    localparam int SECTOR_BYTES = 4096;
    function automatic logic is_req(input logic [2:0] s);
        return s == S_RD_REQ || s == S_ERASE || s == S_WR_REQ;
    endfunction
endpackage

// File: rtl/flash_retry_timer.sv
// flash_retry_timer: after a load, counts WAIT cycles and flags the last one
module flash_retry_timer #(
    parameter int WAIT = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic expire_o
);
    localparam int CW = $clog2(WAIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // reload on request, otherwise count down and park at zero
    always_comb cnt_d = load_i ? CW'(WAIT) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    // counter register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign expire_o = cnt_q == CW'(1);
endmodule

// File: rtl/flash_patch_mover.sv
// flash_patch_mover: moves a patch block between SPI flash and local RAM, hiding busy retries
module flash_patch_mover
    import flash_pkg::*;
#(
    parameter int          WORDS      = 16,
    parameter logic [23:0] BASE_ADR   = 24'h0F0000,
    parameter int          RETRY_WAIT = 1000,
    parameter int          MAX_RETRY  = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     load_i,
    input  logic                     save_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [$clog2(WORDS)-1:0] buf_adr_o,
    output logic [31:0]              buf_dat_o,
    output logic                     buf_we_o,
    input  logic [31:0]              buf_dat_i,
    output logic [23:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    output logic                     m_we_o,
    output logic                     m_tga_o,
    output logic                     m_stb_o,
    input  logic [31:0]              m_dat_i,
    input  logic                     m_ack_i,
    input  logic                     m_rty_i
);
    localparam int AW = $clog2(WORDS);
    localparam int IW = AW + 1;

    logic [2:0]    state_q, state_d, ret_q, ret_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    gap_q, gap_d;
    logic          fetch_q, fetch_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic          stb_q, stb_d, we_q, we_d, tga_q, tga_d;
    logic [23:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [AW-1:0] badr_q, badr_d;
    logic [31:0]   bdat_q, bdat_d;
    logic          bwe_q, bwe_d;
    logic          resp, last, req, tload, expire;

    flash_retry_timer #(.WAIT(RETRY_WAIT)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (tload),
        .expire_o (expire)
    );

    // sequencing; bus and status outputs are derived from the next state so they are registered
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        fetch_d = 1'b0;
        rcnt_d  = rcnt_q;
        wdat_d  = wdat_q;
        err_d   = err_q;
        badr_d  = badr_q;
        bdat_d  = bdat_q;
        bwe_d   = 1'b0;
        tload   = 1'b0;
        resp    = stb_q && (m_ack_i || m_rty_i);
        last    = idx_q == IW'(WORDS - 1);
        case (state_q)
            S_IDLE: if (load_i || save_i) begin
                state_d = load_i ? S_RD_REQ : S_ERASE;
                err_d   = 1'b0;
                idx_d   = '0;
                rcnt_d  = '0;
            end
            S_RD_REQ, S_ERASE, S_WR_REQ: if (resp) begin
                if (m_rty_i) begin
                    if (rcnt_q == 8'(MAX_RETRY)) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        ret_d   = state_q;
                        state_d = S_RETRY;
                        tload   = 1'b1;
                    end
                end else begin
                    rcnt_d = '0;
                    if (state_q == S_ERASE) begin
                        state_d = S_GAP;
                        ret_d   = S_WR_FETCH;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = last ? S_FINISH : S_GAP;
                        ret_d   = state_q == S_RD_REQ ? S_RD_REQ : S_WR_FETCH;
                    end
                    if (state_q == S_RD_REQ) begin
                        bwe_d  = 1'b1;
                        badr_d = idx_q[AW-1:0];
                        bdat_d = m_dat_i;
                    end
                end
            end
            S_WR_FETCH: begin
                if (fetch_q) begin
                    wdat_d  = buf_dat_i;
                    state_d = S_WR_REQ;
                end else fetch_d = 1'b1;
            end
            S_GAP: begin
                if (gap_q == 2'd0) state_d = ret_q;
                else gap_d = gap_q - 2'd1;
            end
            S_RETRY: if (expire) state_d = ret_q;
            S_FINISH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_GAP && state_q != S_GAP) gap_d = 2'(GAP_LEN - 1);
        if (state_d == S_WR_FETCH) badr_d = idx_d[AW-1:0];
        req    = is_req(state_d);
        stb_d  = req;
        we_d   = req && state_d != S_RD_REQ;
        tga_d  = state_d == S_ERASE;
        adr_d  = req ? BASE_ADR + 24'({idx_d, 2'b00}) : '0;
        dat_d  = state_d == S_WR_REQ ? wdat_d : '0;
        busy_d = state_d != S_IDLE && state_d != S_FINISH;
        done_d = state_d == S_FINISH;
    end

    // state and output registers; reset drops the bus request at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            fetch_q <= 1'b0;
            rcnt_q  <= '0;
            wdat_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            tga_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            badr_q  <= '0;
            bdat_q  <= '0;
            bwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            fetch_q <= fetch_d;
            rcnt_q  <= rcnt_d;
            wdat_q  <= wdat_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            tga_q   <= tga_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            badr_q  <= badr_d;
            bdat_q  <= bdat_d;
            bwe_q   <= bwe_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign buf_adr_o = badr_q;
    assign buf_dat_o = bdat_q;
    assign buf_we_o  = bwe_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign m_we_o    = we_q;
    assign m_tga_o   = tga_q;
    assign m_stb_o   = stb_q;
endmodule

// File: tb/tb_flash_patch_mover.sv
// tb_flash_patch_mover: directed and randomized load/save runs against a flash slave and RAM model
module tb_flash_patch_mover;
    localparam int          WORDS = 4;
    localparam logic [23:0] BASE  = 24'h0F0000;
    localparam int          RW    = 20;
    localparam int          MR    = 2;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic        load_i = 1'b0, save_i = 1'b0;
    logic        busy_o, done_o, err_o, buf_we_o, m_we_o, m_tga_o, m_stb_o;
    logic [1:0]  buf_adr_o;
    logic [31:0] buf_dat_o, buf_dat_i, m_dat_o, m_dat_i;
    logic [23:0] m_adr_o;
    logic        m_ack_i, m_rty_i;
    int          checks = 0, errors = 0;

    logic [31:0] ram [WORDS], ram_init [WORDS], flash [WORDS], flash_init [WORDS];
    int          rty_plan [WORDS+1];
    int          lat_target = 1;
    bit          busy_forever = 1'b0;

    int          lat, n_ack, n_rty, rty_req;
    bit          answered;
    logic [25:0] log_c [WORDS+1];

    int          low_cnt, bus_viol, retry_bad, done_cnt, wr_seen, stb_seen;
    bit          prev_stb, last_rty;
    logic [57:0] prev_bus;

    always #5 clk = ~clk;

    flash_patch_mover #(.WORDS(WORDS), .BASE_ADR(BASE), .RETRY_WAIT(RW), .MAX_RETRY(MR)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load_i), .save_i(save_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .buf_adr_o(buf_adr_o), .buf_dat_o(buf_dat_o), .buf_we_o(buf_we_o), .buf_dat_i(buf_dat_i),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_tga_o(m_tga_o), .m_stb_o(m_stb_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_rty_i(m_rty_i)
    );

    function automatic int fidx(input logic [23:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // patch RAM: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (clr) for (int i = 0; i < WORDS; i++) ram[i] <= ram_init[i];
        else if (buf_we_o) ram[buf_adr_o] <= buf_dat_o;
        buf_dat_i <= ram[buf_adr_o];
    end

    // flash slave: answers each request after lat_target cycles, rty first as planned
    always @(negedge clk) begin
        if (rst || clr) begin
            m_ack_i <= 1'b0; m_rty_i <= 1'b0; m_dat_i <= '0; answered <= 1'b0;
            lat <= 0; n_ack <= 0; n_rty <= 0; rty_req <= 0;
            if (clr) for (int i = 0; i < WORDS; i++) flash[i] <= flash_init[i];
        end else if (!m_stb_o || answered) begin
            m_ack_i <= 1'b0; m_rty_i <= 1'b0; lat <= 0; answered <= answered && m_stb_o;
        end else if (lat < lat_target) lat <= lat + 1;
        else begin
            answered <= 1'b1;
            if (busy_forever || (n_ack <= WORDS && rty_req < rty_plan[n_ack])) begin
                m_rty_i <= 1'b1; n_rty <= n_rty + 1; rty_req <= rty_req + 1;
            end else begin
                m_ack_i <= 1'b1; rty_req <= 0; n_ack <= n_ack + 1;
                if (n_ack <= WORDS) log_c[n_ack] <= {m_we_o, m_tga_o, m_adr_o};
                if (m_we_o && m_tga_o) for (int i = 0; i < WORDS; i++) flash[i] <= 32'hFFFF_FFFF;
                else if (fidx(m_adr_o) < WORDS) begin
                    if (m_we_o) flash[fidx(m_adr_o)] <= m_dat_o;
                    else m_dat_i <= flash[fidx(m_adr_o)];
                end
            end
        end
    end

    // bus monitor: request stability, minimum gap, exact retry spacing, done pulses
    always @(negedge clk) begin
        if (rst || clr) begin
            low_cnt <= 100; prev_stb <= 1'b0; last_rty <= 1'b0; prev_bus <= '0;
            bus_viol <= 0; retry_bad <= 0; done_cnt <= 0; wr_seen <= 0; stb_seen <= 0;
        end else begin
            if (done_o) done_cnt <= done_cnt + 1;
            if (m_rty_i) last_rty <= 1'b1;
            else if (m_ack_i) last_rty <= 1'b0;
            if (m_stb_o) begin
                stb_seen <= stb_seen + 1;
                low_cnt <= 0;
                if (m_we_o) wr_seen <= wr_seen + 1;
                if (prev_stb && prev_bus != {m_adr_o, m_dat_o, m_we_o, m_tga_o}) bus_viol <= bus_viol + 1;
                if (!prev_stb && last_rty && low_cnt != RW) retry_bad <= retry_bad + 1;
                if (!prev_stb && !last_rty && low_cnt < 2) bus_viol <= bus_viol + 1;
            end else if (low_cnt < 100000) low_cnt <= low_cnt + 1;
            prev_stb <= m_stb_o;
            prev_bus <= {m_adr_o, m_dat_o, m_we_o, m_tga_o};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic start(input bit l, input bit s, input string tag);
        load_i = l;
        save_i = s;
        tick();
        load_i = 1'b0;
        save_i = 1'b0;
        check({tag, " busy"}, 32'(busy_o), 1);
        check({tag, " err cleared"}, 32'(err_o), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 20000) begin
            tick();
            n++;
        end
        check({tag, " done"}, 32'(done_o), 1);
        repeat (4) tick();
    endtask

    // expected request sequence, final memory image and retry count of a clean operation
    task automatic check_op(input string tag, input bit save, input int exp_rty);
        check({tag, " acks"}, 32'(n_ack), save ? WORDS + 1 : WORDS);
        check({tag, " rtys"}, 32'(n_rty), 32'(exp_rty));
        if (save) check({tag, " erase"}, 32'(log_c[0]), {6'd0, 2'b11, BASE});
        for (int k = 0; k < WORDS; k++) begin
            check($sformatf("%s req%0d", tag, k), 32'(log_c[save ? k + 1 : k]),
                  {6'd0, save, 1'b0, BASE + 24'(4 * k)});
            if (save) check($sformatf("%s flash%0d", tag, k), flash[k], ram_init[k]);
            else check($sformatf("%s ram%0d", tag, k), ram[k], flash_init[k]);
        end
        check({tag, " done pulses"}, 32'(done_cnt), 1);
        check({tag, " err"}, 32'(err_o), 0);
        check({tag, " busy idle"}, 32'(busy_o), 0);
        check({tag, " bus"}, 32'(bus_viol), 0);
        check({tag, " retry wait"}, 32'(retry_bad), 0);
    endtask

    initial begin
        int n, s, exp_rty;
        for (int i = 0; i <= WORDS; i++) rty_plan[i] = 0;
        for (int i = 0; i < WORDS; i++) begin
            ram_init[i] = '0;
            flash_init[i] = '0;
        end
        repeat (3) tick();
        check("rst busy", 32'(busy_o), 0);
        check("rst done", 32'(done_o), 0);
        check("rst err", 32'(err_o), 0);
        check("rst stb", 32'(m_stb_o), 0);
        check("rst bus", {m_adr_o, m_we_o, m_tga_o, buf_we_o, 5'd0}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < WORDS; i++) flash_init[i] = 32'hA0 + 32'(i);
        lat_target = 40;
        clear();
        start(1'b1, 1'b0, "load40");
        wait_done("load40");
        check_op("load40", 1'b0, 0);

        for (int i = 0; i < WORDS; i++) begin
            ram_init[i] = 32'hDEAD_0000 + 32'(i);
            flash_init[i] = $urandom;
        end
        for (int i = 1; i <= 3; i++) rty_plan[i] = 1;
        lat_target = 3;
        clear();
        start(1'b0, 1'b1, "save_rty");
        wait_done("save_rty");
        check_op("save_rty", 1'b1, 3);

        for (int i = 0; i <= WORDS; i++) rty_plan[i] = 0;
        busy_forever = 1'b1;
        clear();
        start(1'b0, 1'b1, "abort");
        wait_done("abort");
        check("abort rtys", 32'(n_rty), MR + 1);
        check("abort acks", 32'(n_ack), 0);
        check("abort err", 32'(err_o), 1);
        check("abort done pulses", 32'(done_cnt), 1);
        check("abort retry wait", 32'(retry_bad), 0);
        s = stb_seen;
        repeat (50) tick();
        check("abort no restart", 32'(stb_seen), 32'(s));
        check("abort err sticky", 32'(err_o), 1);
        busy_forever = 1'b0;

        for (int i = 0; i < WORDS; i++) flash_init[i] = $urandom;
        lat_target = 2;
        clear();
        start(1'b1, 1'b1, "both");
        repeat (10) tick();
        save_i = 1'b1;
        tick();
        save_i = 1'b0;
        wait_done("both");
        check("both no writes", 32'(wr_seen), 0);
        check_op("both", 1'b0, 0);

        for (int i = 0; i < WORDS; i++) ram_init[i] = $urandom;
        clear();
        start(1'b0, 1'b1, "rst_mid");
        n = 0;
        while (!(m_stb_o && m_we_o && !m_tga_o) && n < 2000) begin
            tick();
            n++;
        end
        check("rst_mid write seen", 32'(m_stb_o && m_we_o && !m_tga_o), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid stb", 32'(m_stb_o), 0);
        check("rst_mid busy", 32'(busy_o), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_mid no done", 32'(done_cnt), 0);
        check("rst_mid idle", 32'(busy_o), 0);
        for (int i = 0; i < WORDS; i++) flash_init[i] = $urandom;
        clear();
        start(1'b1, 1'b0, "after_rst");
        wait_done("after_rst");
        check_op("after_rst", 1'b0, 0);

        for (int it = 0; it < 6; it++) begin
            exp_rty = 0;
            for (int i = 0; i < WORDS; i++) begin
                ram_init[i] = $urandom;
                flash_init[i] = $urandom;
            end
            for (int i = 0; i <= WORDS; i++) begin
                rty_plan[i] = int'($urandom_range(0, MR));
                if (it[0] || i < WORDS) exp_rty += rty_plan[i];
            end
            lat_target = int'($urandom_range(1, 6));
            clear();
            start(!it[0], it[0], $sformatf("rand%0d", it));
            wait_done($sformatf("rand%0d", it));
            check_op($sformatf("rand%0d", it), it[0], exp_rty);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
